// File: rtl/ioctl_rom_loader.sv
// Purpose: packs the hps_io ioctl byte stream into BYTES-wide SDRAM words and captures DIP switch bytes.
// Latency: one SDRAM request per word; the request toggles two edges after the byte that completes the word.
// Backpressure: ioctl_wait is held from word completion until the toggle ack returns; a one-byte skid absorbs late bytes.
//
// Ports:
//   clk_sys, reset         system clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout   hps_io download byte stream
//   ioctl_wait             stall request back to hps_io
//   sdr_addr/din/be        word address, packed word and byte enables of the current request
//   sdr_req / sdr_ack      toggle handshake; done when sdr_ack == sdr_req
//   dip_sw                 DIP byte registers, register k at bits [8k+7:8k]
//   load_err               sticky: a byte was dropped because the skid was full
// Optional: define IOCTL_ROM_LOADER_CHECKSUM_EN to add rom_sum / rom_sum_valid.
module ioctl_rom_loader #(
    parameter int BYTES     = 2,
    parameter int ADDR_W    = 24,
    parameter int ROM_INDEX = 0,
    parameter int DIP_INDEX = 254,
    parameter int DIP_BYTES = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [ADDR_W-1:0]      sdr_addr,
    output logic [8*BYTES-1:0]     sdr_din,
    output logic [BYTES-1:0]       sdr_be,
    output logic                   sdr_req,
    input  logic                   sdr_ack,
    output logic [8*DIP_BYTES-1:0] dip_sw,
    output logic                   load_err
`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]            rom_sum,
    output logic                   rom_sum_valid
`endif
);

    localparam int LOG2B = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_ACK} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  buf_addr;
    logic [8*BYTES-1:0] buf_din;
    logic [BYTES-1:0]   buf_be;
    logic               skid_vld;
    logic [24:0]        skid_addr;
    logic [7:0]         skid_dat;
    // The request toggle survives reset so a request in flight is never re-toggled.
    logic               req_q = 1'b0;
    logic               ack_shadow;
    logic               dl_prev;

    function automatic logic [ADDR_W-1:0] word_of(input logic [24:0] a);
        return ADDR_W'(a >> LOG2B);
    endfunction

    function automatic logic [BYTES-1:0] lane_of(input logic [24:0] a);
        logic [BYTES-1:0] m;
        m = '0;
        for (int k = 0; k < BYTES; k++)
            if ((a & 25'(BYTES - 1)) == 25'(k)) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [8*BYTES-1:0] lane_put(input logic [BYTES-1:0] m, input logic [7:0] d,
                                                    input logic [8*BYTES-1:0] old);
        logic [8*BYTES-1:0] r;
        r = old;
        for (int k = 0; k < BYTES; k++)
            if (m[k]) r[8*k +: 8] = d;
        return r;
    endfunction

    logic             rom_wr, dip_wr, same_word, ack_done, dl_rise;
    logic [BYTES-1:0] in_lane;
    state_t           fresh_nxt;

    assign rom_wr    = ioctl_wr && (ioctl_index == 8'(ROM_INDEX));
    assign dip_wr    = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr < 25'(DIP_BYTES));
    assign in_lane   = lane_of(ioctl_addr);
    assign same_word = (word_of(ioctl_addr) == buf_addr);
    assign dl_rise   = ioctl_download && !dl_prev;
    // The shadow holds the ack level seen before the request, so only a real ack edge completes it.
    assign ack_done  = (state == WAIT_ACK) && (sdr_ack == req_q) && (sdr_ack != ack_shadow);
    // A lone byte is already a full word when BYTES==1, and must go out at once if the download has ended.
    assign fresh_nxt = ((BYTES == 1) || !ioctl_download) ? ISSUE : FILL;

    logic buf_load, skid_load, buf_merge, be_clr, skid_wr, skid_rd, drop;

    always_comb begin
        state_nxt = state;
        buf_load  = 1'b0;
        skid_load = 1'b0;
        buf_merge = 1'b0;
        be_clr    = 1'b0;
        skid_wr   = 1'b0;
        skid_rd   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (rom_wr) begin
                    buf_load  = 1'b1;
                    state_nxt = fresh_nxt;
                end
            end
            FILL: begin
                if (rom_wr && same_word) begin
                    buf_merge = 1'b1;
                    if (((buf_be | in_lane) == {BYTES{1'b1}}) || !ioctl_download) state_nxt = ISSUE;
                end else if (rom_wr) begin
                    // Address jump: flush the partial word, park the new byte.
                    skid_wr   = 1'b1;
                    state_nxt = ISSUE;
                end else if (!ioctl_download) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
                if (rom_wr) begin
                    drop    = skid_vld;
                    skid_wr = !skid_vld;
                end
            end
            WAIT_ACK: begin
                if (ack_done) begin
                    be_clr = 1'b1;
                    if (skid_vld) begin
                        skid_load = 1'b1;
                        skid_rd   = 1'b1;
                        drop      = rom_wr;
                        state_nxt = fresh_nxt;
                    end else if (rom_wr) begin
                        buf_load  = 1'b1;
                        state_nxt = fresh_nxt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rom_wr) begin
                    drop    = skid_vld;
                    skid_wr = !skid_vld;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            buf_addr   <= '0;
            buf_din    <= '0;
            buf_be     <= '0;
            skid_vld   <= 1'b0;
            skid_addr  <= '0;
            skid_dat   <= '0;
            ack_shadow <= sdr_ack;
            dl_prev    <= 1'b0;
            ioctl_wait <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dl_prev    <= ioctl_download;
            ioctl_wait <= (state_nxt == ISSUE) || (state_nxt == WAIT_ACK);
            if (state != WAIT_ACK) ack_shadow <= sdr_ack;
            if (state == ISSUE) req_q <= ~req_q;

            if (buf_load) begin
                buf_addr <= word_of(ioctl_addr);
                buf_be   <= in_lane;
                buf_din  <= lane_put(in_lane, ioctl_dout, '0);
            end else if (skid_load) begin
                buf_addr <= word_of(skid_addr);
                buf_be   <= lane_of(skid_addr);
                buf_din  <= lane_put(lane_of(skid_addr), skid_dat, '0);
            end else if (buf_merge) begin
                buf_be   <= buf_be | in_lane;
                buf_din  <= lane_put(in_lane, ioctl_dout, buf_din);
            end else if (be_clr) begin
                buf_be   <= '0;
            end

            if (skid_wr) begin
                skid_vld  <= 1'b1;
                skid_addr <= ioctl_addr;
                skid_dat  <= ioctl_dout;
            end else if (skid_rd) begin
                skid_vld  <= 1'b0;
            end

            if (drop)         load_err <= 1'b1;
            else if (dl_rise) load_err <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dip_sw <= '0;
        end else if (dip_wr) begin
            for (int k = 0; k < DIP_BYTES; k++)
                if (ioctl_addr == 25'(k)) dip_sw[8*k +: 8] <= ioctl_dout;
        end
    end

    assign sdr_addr = buf_addr;
    assign sdr_din  = buf_din;
    assign sdr_be   = buf_be;
    assign sdr_req  = req_q;

`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
    logic accept;
    assign accept = rom_wr && !drop;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_sum       <= '0;
            rom_sum_valid <= 1'b0;
        end else begin
            if (dl_rise)     rom_sum <= accept ? {8'h00, ioctl_dout} : 16'h0000;
            else if (accept) rom_sum <= rom_sum + {8'h00, ioctl_dout};
            // Valid once the machine has settled in IDLE after the download ended.
            rom_sum_valid <= !ioctl_download && (state == IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_ioctl_rom_loader.sv
module tb_ioctl_rom_loader;

    localparam int OP_BYTE  = 0;
    localparam int OP_START = 1;
    localparam int OP_END   = 2;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        int          op;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dat;
        bit          exp_vld;
        logic [23:0] exp_addr;
        logic [15:0] exp_din;
        logic [1:0]  exp_be;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        sel4 = 1'b0;
    logic        wr2, wr4;

    logic        wait2, wait4, req2, req4, err2, err4;
    logic        ack2 = 1'b0, ack4 = 1'b0;
    logic [23:0] addr2, addr4;
    logic [15:0] din2;
    logic [31:0] din4;
    logic [1:0]  be2;
    logic [3:0]  be4;
    logic [63:0] dip2, dip4;
`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum2, sum4;
    logic        sumv2, sumv4;
`endif

    assign wr2 = ioctl_wr && !sel4;
    assign wr4 = ioctl_wr && sel4;

    always #5 clk_sys = ~clk_sys;

    ioctl_rom_loader #(.BYTES(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(wr2), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait2),
        .sdr_addr(addr2), .sdr_din(din2), .sdr_be(be2), .sdr_req(req2), .sdr_ack(ack2),
        .dip_sw(dip2), .load_err(err2)
`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
        , .rom_sum(sum2), .rom_sum_valid(sumv2)
`endif
    );

    ioctl_rom_loader #(.BYTES(4)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(wr4), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait4),
        .sdr_addr(addr4), .sdr_din(din4), .sdr_be(be4), .sdr_req(req4), .sdr_ack(ack4),
        .dip_sw(dip4), .load_err(err4)
`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
        , .rom_sum(sum4), .rom_sum_valid(sumv4)
`endif
    );

    int  n_checks = 0;
    int  n_fail = 0;
    int  n_push2 = 0;
    wr_t q2[$];
    wr_t q4[$];
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    // SDRAM ack responders: return the toggle a few cycles after the request, optionally held off.
    bit hold2 = 1'b0;
    int cnt2 = 0, cnt4 = 0;
    always @(posedge clk_sys) begin
        if (ack2 != req2) begin
            if (!hold2 && cnt2 >= 5) begin ack2 <= req2; cnt2 <= 0; end
            else cnt2 <= cnt2 + 1;
        end
        if (ack4 != req4) begin
            if (cnt4 >= 3) begin ack4 <= req4; cnt4 <= 0; end
            else cnt4 <= cnt4 + 1;
        end
    end

    // Scoreboard monitors: every request toggle pops one expected word.
    logic mon2 = 1'b0, mon4 = 1'b0;
    always @(negedge clk_sys) begin
        wr_t e;
        if (req2 !== mon2) begin
            mon2 = req2;
            if (q2.size() == 0) check("dut2_unexpected_req", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                check("dut2_addr", 64'(addr2), 64'(e.addr));
                check("dut2_be", 64'(be2), 64'(e.be));
                check("dut2_din", 64'({16'h0, din2} & bmask({2'b00, be2})), 64'(e.din & bmask(e.be)));
            end
        end
        if (req4 !== mon4) begin
            mon4 = req4;
            if (q4.size() == 0) check("dut4_unexpected_req", 64'd1, 64'd0);
            else begin
                e = q4.pop_front();
                check("dut4_addr", 64'(addr4), 64'(e.addr));
                check("dut4_be", 64'(be4), 64'(e.be));
                check("dut4_din", 64'(din4 & bmask(be4)), 64'(e.din & bmask(e.be)));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push2(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b);
        q2.push_back({a, d, b});
        n_push2++;
    endtask

    task automatic wait_ready(input bit to4);
        int n = 0;
        while ((to4 ? wait4 : wait2) && n < 200) begin tick(); n++; end
        check("wait_ready", 64'(to4 ? wait4 : wait2), 64'd0);
    endtask

    task automatic send(input bit to4, input logic [7:0] idx, input logic [24:0] a,
                        input logic [7:0] d, input bit honor);
        if (honor) wait_ready(to4);
        sel4 = to4; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; sel4 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q2.size() != 0 || q4.size() != 0 || wait2 || wait4 || ack2 != req2 || ack4 != req4) && n < 400) begin
            tick(); n++;
        end
        check("drain_q2", 64'(q2.size()), 64'd0);
        check("drain_q4", 64'(q4.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_START, 8'd0, 25'd0,  8'h00, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[1]  = '{OP_BYTE,  8'd0, 25'd4,  8'h01, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[2]  = '{OP_BYTE,  8'd0, 25'd11, 8'h02, 1'b1, 24'd2,  16'h0001, 2'b01};
        vecs[3]  = '{OP_END,   8'd0, 25'd0,  8'h00, 1'b1, 24'd5,  16'h0200, 2'b10};
        vecs[4]  = '{OP_START, 8'd0, 25'd0,  8'h00, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[5]  = '{OP_BYTE,  8'd0, 25'd20, 8'h44, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[6]  = '{OP_BYTE,  8'd0, 25'd21, 8'h55, 1'b1, 24'd10, 16'h5544, 2'b11};
        vecs[7]  = '{OP_BYTE,  8'd0, 25'd30, 8'h66, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[8]  = '{OP_BYTE,  8'd0, 25'd30, 8'h77, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[9]  = '{OP_BYTE,  8'd0, 25'd31, 8'h88, 1'b1, 24'd15, 16'h8877, 2'b11};
        vecs[10] = '{OP_BYTE,  8'd5, 25'd40, 8'h99, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[11] = '{OP_BYTE,  8'd0, 25'd41, 8'hEE, 1'b0, 24'd0,  16'h0000, 2'b00};
        vecs[12] = '{OP_END,   8'd0, 25'd0,  8'h00, 1'b1, 24'd20, 16'hEE00, 2'b10};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_wait", 64'(wait2), 64'd0);
        check("rst_req", 64'(req2), 64'd0);
        check("rst_be", 64'(be2), 64'd0);
        check("rst_din", 64'(din2), 64'd0);
        check("rst_addr", 64'(addr2), 64'd0);
        check("rst_err", 64'(err2), 64'd0);
        check("rst_dip", dip2, 64'd0);
        reset = 1'b0;
        tick();

        // Two bytes form one full word; wait stays high until the ack returns.
        ioctl_download = 1'b1;
        tick();
        send(1'b0, 8'd0, 25'd0, 8'h11, 1'b1);
        push2(24'd0, 32'h2211, 4'b0011);
        send(1'b0, 8'd0, 25'd1, 8'h22, 1'b1);
        check("t1_wait_set", 64'(wait2), 64'd1);
        begin
            int n = 0;
            while (ack2 !== 1'b1 && n < 100) begin tick(); n++; end
        end
        check("t1_ack_seen", 64'(ack2), 64'd1);
        check("t1_wait_at_ack", 64'(wait2), 64'd1);
        tick();
        check("t1_wait_clear", 64'(wait2), 64'd0);
        drain();

        // Vector table: discontinuity flush, end-of-download flush, lane overwrite, foreign index.
        for (int i = 0; i < 13; i++) begin
            case (vecs[i].op)
                OP_START: begin ioctl_download = 1'b1; tick(); end
                OP_END: begin
                    wait_ready(1'b0);
                    if (vecs[i].exp_vld) push2(vecs[i].exp_addr, {16'h0, vecs[i].exp_din}, {2'b00, vecs[i].exp_be});
                    ioctl_download = 1'b0;
                    tick();
                end
                default: begin
                    if (vecs[i].exp_vld) push2(vecs[i].exp_addr, {16'h0, vecs[i].exp_din}, {2'b00, vecs[i].exp_be});
                    send(1'b0, vecs[i].idx, vecs[i].addr, vecs[i].dat, 1'b1);
                end
            endcase
        end
        drain();
        check("tbl_err", 64'(err2), 64'd0);

        // Ack held off: one byte parks in the skid, the next is dropped.
        ioctl_download = 1'b1;
        tick();
        hold2 = 1'b1;
        send(1'b0, 8'd0, 25'd100, 8'h11, 1'b1);
        push2(24'd50, 32'h2211, 4'b0011);
        send(1'b0, 8'd0, 25'd101, 8'h22, 1'b1);
        send(1'b0, 8'd0, 25'd102, 8'h33, 1'b0);
        send(1'b0, 8'd0, 25'd103, 8'h44, 1'b0);
        check("t4_err_set", 64'(err2), 64'd1);
        repeat (20) tick();
        check("t4_wait_held", 64'(wait2), 64'd1);
        hold2 = 1'b0;
        wait_ready(1'b0);
        push2(24'd51, 32'h0033, 4'b0001);
        ioctl_download = 1'b0;
        tick();
        drain();
        check("t4_err_sticky", 64'(err2), 64'd1);
        ioctl_download = 1'b1;
        tick();
        tick();
        check("t4_err_cleared", 64'(err2), 64'd0);

        // Reset while a request is outstanding: req keeps its level, no spurious toggle.
        hold2 = 1'b1;
        send(1'b0, 8'd0, 25'd60, 8'h12, 1'b1);
        push2(24'd30, 32'h3412, 4'b0011);
        send(1'b0, 8'd0, 25'd61, 8'h34, 1'b1);
        begin
            int n = 0;
            while (req2 !== n_push2[0] && n < 20) begin tick(); n++; end
        end
        check("t5_req_toggled", 64'(req2), 64'(n_push2[0]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t5_req_kept", 64'(req2), 64'(n_push2[0]));
        check("t5_wait_clr", 64'(wait2), 64'd0);
        check("t5_be_clr", 64'(be2), 64'd0);
        hold2 = 1'b0;
        repeat (10) tick();
        check("t5_no_spurious", 64'(req2), 64'(n_push2[0]));
        send(1'b0, 8'd0, 25'd62, 8'h56, 1'b1);
        push2(24'd31, 32'h7856, 4'b0011);
        send(1'b0, 8'd0, 25'd63, 8'h78, 1'b1);
        drain();

        // DIP capture: in-range bytes land in their register, out-of-range ignored, never stalls.
        send(1'b0, 8'd254, 25'd1, 8'h5A, 1'b1);
        check("dip_5a", dip2, 64'h0000_0000_0000_5A00);
        check("dip_wait0", 64'(wait2), 64'd0);
        send(1'b0, 8'd254, 25'd9, 8'hFF, 1'b1);
        check("dip_oob", dip2, 64'h0000_0000_0000_5A00);
        check("dip_wait1", 64'(wait2), 64'd0);
        send(1'b0, 8'd254, 25'd7, 8'hC3, 1'b1);
        check("dip_top", dip2, 64'hC300_0000_0000_5A00);

        // BYTES=4 partial flush at end of download.
        send(1'b1, 8'd0, 25'd8, 8'hAA, 1'b1);
        send(1'b1, 8'd0, 25'd9, 8'hBB, 1'b1);
        wait_ready(1'b1);
        q4.push_back({24'd2, 32'h0000_BBAA, 4'b0011});
        ioctl_download = 1'b0;
        tick();
        drain();

`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
        ioctl_download = 1'b1;
        tick();
        tick();
        check("sum_cleared", 64'(sum2), 64'd0);
        check("sum_valid_low", 64'(sumv2), 64'd0);
        send(1'b0, 8'd0, 25'd0, 8'hFF, 1'b1);
        push2(24'd0, 32'h02FF, 4'b0011);
        send(1'b0, 8'd0, 25'd1, 8'h02, 1'b1);
        send(1'b0, 8'd0, 25'd2, 8'h80, 1'b1);
        wait_ready(1'b0);
        push2(24'd1, 32'h0080, 4'b0001);
        ioctl_download = 1'b0;
        tick();
        drain();
        tick();
        tick();
        check("sum_value", 64'(sum2), 64'h0181);
        check("sum_valid", 64'(sumv2), 64'd1);
`endif

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
